// File: rtl/irq_pending_ctrl_if.sv
// Request/grant bundle between the pending controller, the 8-to-3 encoder and the consumer.
interface irq_pending_ctrl_if #(
    parameter int unsigned N_REQ = 8
);
    localparam int unsigned IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0] req_in;
    logic             mask_wr;
    logic [N_REQ-1:0] mask_data;
    logic [N_REQ-1:0] pend_vec;
    logic [IDX_W-1:0] enc_idx;
    logic             irq_valid;
    logic [IDX_W-1:0] irq_idx;
    logic             irq_ready;
    logic [N_REQ-1:0] pending;
    logic             overflow;
    logic             ovf_clr;

    // Environment side: request sources, mask writer, encoder and grant consumer.
    modport master (
        output req_in,
        output mask_wr,
        output mask_data,
        input  pend_vec,
        output enc_idx,
        input  irq_valid,
        input  irq_idx,
        output irq_ready,
        input  pending,
        input  overflow,
        output ovf_clr
    );

    // Controller side.
    modport slave (
        input  req_in,
        input  mask_wr,
        input  mask_data,
        output pend_vec,
        input  enc_idx,
        output irq_valid,
        output irq_idx,
        input  irq_ready,
        output pending,
        output overflow,
        input  ovf_clr
    );
endinterface

// File: rtl/irq_pending_ctrl.sv
// Sticky pending register, software mask and valid/ready grant front end for the 8-to-3 encoder.
module irq_pending_ctrl #(
    parameter int unsigned N_REQ       = 8,
    parameter bit          EDGE_DETECT = 1'b1
) (
    input logic             clk,
    input logic             rst_n,
    irq_pending_ctrl_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(N_REQ);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nx;

    logic [N_REQ-1:0] pending_q;
    logic [N_REQ-1:0] mask_q;
    logic [N_REQ-1:0] req_q;
    logic [N_REQ-1:0] set_vec;
    logic [N_REQ-1:0] clr_vec;
    logic [N_REQ-1:0] pend_vec_c;
    logic [IDX_W-1:0] idx_q;
    logic             ovf_q;
    logic             ovf_hit;
    logic             valid_c;
    logic             grant_load;
    logic             ack;

    generate
        if (EDGE_DETECT) begin : g_edge
            assign set_vec = bus.req_in & ~req_q;
        end else begin : g_level
            assign set_vec = bus.req_in;
        end
    endgenerate

    assign pend_vec_c = pending_q & mask_q;

    always_comb begin
        clr_vec = '0;
        if (ack) begin
            clr_vec[idx_q] = 1'b1;
        end
    end

    // A re-request only counts as overflow if the bit is not being serviced this same edge.
    assign ovf_hit = |(set_vec & pending_q & ~clr_vec);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q     <= '0;
            pending_q <= '0;
            mask_q    <= '1;
            ovf_q     <= 1'b0;
        end else begin
            req_q     <= bus.req_in;
            pending_q <= (pending_q & ~clr_vec) | set_vec;
            if (bus.mask_wr) begin
                mask_q <= bus.mask_data;
            end
            ovf_q     <= ovf_hit | (ovf_q & ~bus.ovf_clr);
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM: next state
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (|pend_vec_c) begin
                    state_nx = PRESENT;
                end
            end
            PRESENT: begin
                if (bus.irq_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        valid_c    = 1'b0;
        grant_load = 1'b0;
        ack        = 1'b0;
        case (state)
            IDLE: begin
                grant_load = |pend_vec_c;
            end
            PRESENT: begin
                valid_c = 1'b1;
                ack     = bus.irq_ready;
            end
            default: begin
                valid_c = 1'b0;
            end
        endcase
    end

    // Index is captured once per grant and held; later arrivals or mask changes do not disturb it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else if (grant_load) begin
            idx_q <= bus.enc_idx;
        end
    end

    assign bus.pend_vec  = pend_vec_c;
    assign bus.irq_valid = valid_c;
    assign bus.irq_idx   = idx_q;
    assign bus.pending   = pending_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed bench for irq_pending_ctrl with a behavioural 8-to-3 priority encoder in the loop.
module tb_irq_pending_ctrl;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    irq_pending_ctrl_if #(.N_REQ(8)) bus ();

    irq_pending_ctrl #(.N_REQ(8), .EDGE_DETECT(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Encoder: index of highest set bit, bit 7 highest.
    always_comb begin
        bus.enc_idx = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (bus.pend_vec[i]) begin
                bus.enc_idx = 3'(i);
            end
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        bus.irq_ready = 1'b1;
        for (int i = 0; i < 40 && (bus.pending !== 8'h00 || bus.irq_valid !== 1'b0); i++) begin
            tick();
        end
        n_cmp++; if (bus.pending !== 8'h00 || bus.irq_valid !== 1'b0) begin n_bad++; $display("FAIL %s_drain: pending=%h valid=%b, required pending=00 valid=0", name, bus.pending, bus.irq_valid); end
    endtask

    task automatic test_reset();
        #3;
        n_cmp++; if (bus.pending !== 8'h00) begin n_bad++; $display("FAIL rst_pending: got %h want 00", bus.pending); end
        n_cmp++; if (bus.pend_vec !== 8'h00) begin n_bad++; $display("FAIL rst_pend_vec: got %h want 00", bus.pend_vec); end
        n_cmp++; if (bus.irq_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", bus.irq_valid); end
        n_cmp++; if (bus.irq_idx !== 3'd0) begin n_bad++; $display("FAIL rst_idx: got %0d want 0", bus.irq_idx); end
        n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL rst_overflow: got %b want 0", bus.overflow); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        bus.irq_ready = 1'b1;
        bus.req_in = 8'h04;
        tick();
        bus.req_in = 8'h00;
        n_cmp++; if (bus.pending !== 8'h04) begin n_bad++; $display("FAIL t1_pending_e1: got %h want 04", bus.pending); end
        n_cmp++; if (bus.irq_valid !== 1'b0) begin n_bad++; $display("FAIL t1_valid_e1: got %b want 0", bus.irq_valid); end
        tick();
        n_cmp++; if (bus.irq_valid !== 1'b1 || bus.irq_idx !== 3'd2) begin n_bad++; $display("FAIL t1_grant_e2: valid=%b idx=%0d, required valid=1 idx=2", bus.irq_valid, bus.irq_idx); end
        tick();
        n_cmp++; if (bus.pending !== 8'h00 || bus.irq_valid !== 1'b0) begin n_bad++; $display("FAIL t1_ack_e3: pending=%h valid=%b, required 00/0", bus.pending, bus.irq_valid); end
    endtask

    task automatic test_back_to_back();
        bus.irq_ready = 1'b1;
        bus.req_in = 8'h90;
        tick();
        bus.req_in = 8'h00;
        n_cmp++; if (bus.pending !== 8'h90) begin n_bad++; $display("FAIL t2_pending: got %h want 90", bus.pending); end
        tick();
        n_cmp++; if (bus.irq_valid !== 1'b1 || bus.irq_idx !== 3'd7) begin n_bad++; $display("FAIL t2_grant7: valid=%b idx=%0d, required 1/7", bus.irq_valid, bus.irq_idx); end
        tick();
        n_cmp++; if (bus.irq_valid !== 1'b0 || bus.pending !== 8'h10) begin n_bad++; $display("FAIL t2_gap: valid=%b pending=%h, required 0/10", bus.irq_valid, bus.pending); end
        tick();
        n_cmp++; if (bus.irq_valid !== 1'b1 || bus.irq_idx !== 3'd4) begin n_bad++; $display("FAIL t2_grant4: valid=%b idx=%0d, required 1/4", bus.irq_valid, bus.irq_idx); end
        tick();
        n_cmp++; if (bus.irq_valid !== 1'b0 || bus.pending !== 8'h00) begin n_bad++; $display("FAIL t2_end: valid=%b pending=%h, required 0/00", bus.irq_valid, bus.pending); end
    endtask

    task automatic test_hold_overflow();
        bus.irq_ready = 1'b0;
        bus.req_in = 8'h04;
        tick();
        bus.req_in = 8'h00;
        tick();
        n_cmp++; if (bus.irq_valid !== 1'b1 || bus.irq_idx !== 3'd2) begin n_bad++; $display("FAIL t3_grant2: valid=%b idx=%0d, required 1/2", bus.irq_valid, bus.irq_idx); end
        tick();
        bus.req_in = 8'hFF;
        tick();
        bus.req_in = 8'h00;
        n_cmp++; if (bus.overflow !== 1'b1) begin n_bad++; $display("FAIL t3_overflow: got %b want 1", bus.overflow); end
        n_cmp++; if (bus.pending !== 8'hFF) begin n_bad++; $display("FAIL t3_pending_ff: got %h want ff", bus.pending); end
        tick(); tick(); tick();
        n_cmp++; if (bus.irq_valid !== 1'b1 || bus.irq_idx !== 3'd2) begin n_bad++; $display("FAIL t3_hold2: valid=%b idx=%0d, required 1/2", bus.irq_valid, bus.irq_idx); end
        bus.irq_ready = 1'b1;
        tick();
        n_cmp++; if (bus.irq_valid !== 1'b0 || bus.pending !== 8'hFB) begin n_bad++; $display("FAIL t3_ack: valid=%b pending=%h, required 0/fb", bus.irq_valid, bus.pending); end
        tick();
        n_cmp++; if (bus.irq_valid !== 1'b1 || bus.irq_idx !== 3'd7) begin n_bad++; $display("FAIL t3_next7: valid=%b idx=%0d, required 1/7", bus.irq_valid, bus.irq_idx); end
        drain("t3");
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL t3_ovf_clr: got %b want 0", bus.overflow); end
    endtask

    task automatic test_mask();
        bus.irq_ready = 1'b1;
        bus.mask_wr = 1'b1;
        bus.mask_data = 8'h7F;
        tick();
        bus.mask_wr = 1'b0;
        bus.req_in = 8'h82;
        tick();
        bus.req_in = 8'h00;
        n_cmp++; if (bus.pending !== 8'h82 || bus.pend_vec !== 8'h02) begin n_bad++; $display("FAIL t4_masked: pending=%h pend_vec=%h, required 82/02", bus.pending, bus.pend_vec); end
        tick();
        n_cmp++; if (bus.irq_valid !== 1'b1 || bus.irq_idx !== 3'd1) begin n_bad++; $display("FAIL t4_grant1: valid=%b idx=%0d, required 1/1", bus.irq_valid, bus.irq_idx); end
        tick();
        n_cmp++; if (bus.irq_valid !== 1'b0 || bus.pending !== 8'h80) begin n_bad++; $display("FAIL t4_after1: valid=%b pending=%h, required 0/80", bus.irq_valid, bus.pending); end
        tick();
        n_cmp++; if (bus.irq_valid !== 1'b0 || bus.pend_vec !== 8'h00) begin n_bad++; $display("FAIL t4_blocked: valid=%b pend_vec=%h, required 0/00", bus.irq_valid, bus.pend_vec); end
        bus.mask_wr = 1'b1;
        bus.mask_data = 8'hFF;
        tick();
        bus.mask_wr = 1'b0;
        n_cmp++; if (bus.irq_valid !== 1'b0 || bus.pend_vec !== 8'h80) begin n_bad++; $display("FAIL t4_unmask: valid=%b pend_vec=%h, required 0/80", bus.irq_valid, bus.pend_vec); end
        tick();
        n_cmp++; if (bus.irq_valid !== 1'b1 || bus.irq_idx !== 3'd7) begin n_bad++; $display("FAIL t4_grant7: valid=%b idx=%0d, required 1/7", bus.irq_valid, bus.irq_idx); end
        drain("t4");
    endtask

    task automatic test_edge_detect();
        bus.irq_ready = 1'b0;
        bus.req_in = 8'h08;
        tick();
        n_cmp++; if (bus.pending !== 8'h08) begin n_bad++; $display("FAIL t5_pending: got %h want 08", bus.pending); end
        tick();
        n_cmp++; if (bus.irq_valid !== 1'b1 || bus.irq_idx !== 3'd3) begin n_bad++; $display("FAIL t5_grant3: valid=%b idx=%0d, required 1/3", bus.irq_valid, bus.irq_idx); end
        for (int i = 0; i < 8; i++) tick();
        n_cmp++; if (bus.overflow !== 1'b0 || bus.pending !== 8'h08) begin n_bad++; $display("FAIL t5_level_held: overflow=%b pending=%h, required 0/08", bus.overflow, bus.pending); end
        bus.req_in = 8'h00;
        tick();
        bus.req_in = 8'h08;
        tick();
        n_cmp++; if (bus.overflow !== 1'b1) begin n_bad++; $display("FAIL t5_reedge_ovf: got %b want 1", bus.overflow); end
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL t5_ovf_clr: got %b want 0", bus.overflow); end
        bus.req_in = 8'h00;
        bus.irq_ready = 1'b1;
        tick();
        n_cmp++; if (bus.irq_valid !== 1'b0 || bus.pending !== 8'h00) begin n_bad++; $display("FAIL t5_ack: valid=%b pending=%h, required 0/00", bus.irq_valid, bus.pending); end
    endtask

    task automatic test_async_reset();
        bus.irq_ready = 1'b0;
        bus.mask_wr = 1'b1;
        bus.mask_data = 8'h20;
        tick();
        bus.mask_wr = 1'b0;
        bus.req_in = 8'h20;
        tick();
        bus.req_in = 8'h00;
        tick();
        n_cmp++; if (bus.irq_valid !== 1'b1 || bus.irq_idx !== 3'd5) begin n_bad++; $display("FAIL t6_grant5: valid=%b idx=%0d, required 1/5", bus.irq_valid, bus.irq_idx); end
        bus.req_in = 8'h20;
        tick();
        bus.req_in = 8'h00;
        n_cmp++; if (bus.overflow !== 1'b1) begin n_bad++; $display("FAIL t6_pre_ovf: got %b want 1", bus.overflow); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.irq_valid !== 1'b0) begin n_bad++; $display("FAIL t6_async_valid: got %b want 0", bus.irq_valid); end
        n_cmp++; if (bus.irq_idx !== 3'd0) begin n_bad++; $display("FAIL t6_async_idx: got %0d want 0", bus.irq_idx); end
        n_cmp++; if (bus.pending !== 8'h00 || bus.overflow !== 1'b0) begin n_bad++; $display("FAIL t6_async_state: pending=%h overflow=%b, required 00/0", bus.pending, bus.overflow); end
        n_cmp++; if (bus.pend_vec !== 8'h00 || bus.enc_idx !== 3'd0) begin n_bad++; $display("FAIL t6_encoder_in: pend_vec=%h enc_idx=%0d, required 00/0", bus.pend_vec, bus.enc_idx); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        bus.req_in = 8'h01;
        tick();
        bus.req_in = 8'h00;
        n_cmp++; if (bus.pend_vec !== 8'h01) begin n_bad++; $display("FAIL t6_mask_ff: pend_vec=%h want 01", bus.pend_vec); end
        bus.irq_ready = 1'b1;
        tick();
        n_cmp++; if (bus.irq_valid !== 1'b1 || bus.irq_idx !== 3'd0) begin n_bad++; $display("FAIL t6_grant0: valid=%b idx=%0d, required 1/0", bus.irq_valid, bus.irq_idx); end
        tick();
        n_cmp++; if (bus.irq_valid !== 1'b0 || bus.pending !== 8'h00) begin n_bad++; $display("FAIL t6_end: valid=%b pending=%h, required 0/00", bus.irq_valid, bus.pending); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.req_in = 8'h00;
        bus.mask_wr = 1'b0;
        bus.mask_data = 8'h00;
        bus.irq_ready = 1'b0;
        bus.ovf_clr = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_hold_overflow();
        test_mask();
        test_edge_detect();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
